// File: rtl/qpsk_demodulator_pkg.sv
// Shared QPSK definitions: symbol type, constellation constants and demodulator FSM states.
// The modulator uses the same symbol constants so the bit mapping has a single definition.
package qpsk_pkg;
  localparam int SAMPLE_W = 12;

  typedef logic [1:0] qpsk_sym_t;

  localparam qpsk_sym_t SYM_NEG_COS = 2'b00;
  localparam qpsk_sym_t SYM_NEG_SIN = 2'b01;
  localparam qpsk_sym_t SYM_POS_COS = 2'b10;
  localparam qpsk_sym_t SYM_POS_SIN = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_DECIDE = 2'd2
  } qpsk_state_t;
endpackage

// File: rtl/qpsk_demodulator_if.sv
// Sample-in / symbol-out bundle of the QPSK demodulator, plus FSM state for observation.
// QPSK_DEMOD_ERASURE_EN adds the sym_erasure flag.
interface qpsk_demodulator_if #(
  parameter int ACC_W = 27
);
  // sample_valid qualifies rx_sample/sin_ref/cos_ref/sym_start in the same cycle; there is no
  // back-pressure. sym_valid and sync_err are single-cycle pulses; sym_out/corr_mag hold between.
  logic                                 sample_valid;
  logic                                 sym_start;
  logic signed [qpsk_pkg::SAMPLE_W-1:0] rx_sample;
  logic signed [qpsk_pkg::SAMPLE_W-1:0] sin_ref;
  logic signed [qpsk_pkg::SAMPLE_W-1:0] cos_ref;
  qpsk_pkg::qpsk_sym_t                  sym_out;
  logic                                 sym_valid;
  logic [ACC_W-1:0]                     corr_mag;
  logic                                 sync_err;
  qpsk_pkg::qpsk_state_t                state;
`ifdef QPSK_DEMOD_ERASURE_EN
  logic                                 sym_erasure;
`endif

  modport master (
    output sample_valid, sym_start, rx_sample, sin_ref, cos_ref,
    input  sym_out, sym_valid, corr_mag, sync_err, state
`ifdef QPSK_DEMOD_ERASURE_EN
    , input sym_erasure
`endif
  );

  modport slave (
    input  sample_valid, sym_start, rx_sample, sin_ref, cos_ref,
    output sym_out, sym_valid, corr_mag, sync_err, state
`ifdef QPSK_DEMOD_ERASURE_EN
    , output sym_erasure
`endif
  );
endinterface

// File: rtl/qpsk_demodulator_correlator.sv
// Signed multiply-accumulate for one correlation branch: load starts a new window,
// accum adds the next product; otherwise the accumulator holds.
module qpsk_correlator
  import qpsk_pkg::*;
#(
  parameter int ACC_W = 27
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load_i,
  input  logic                       accum_i,
  input  logic signed [SAMPLE_W-1:0] a_i,
  input  logic signed [SAMPLE_W-1:0] b_i,
  output logic signed [ACC_W-1:0]    acc_o
);
  logic signed [2*SAMPLE_W-1:0] prod;
  logic signed [ACC_W-1:0]      prod_ext;
  logic signed [ACC_W-1:0]      acc_d;
  logic signed [ACC_W-1:0]      acc_q;

  always_comb begin
    prod     = a_i * b_i;
    prod_ext = ACC_W'(prod);
    acc_d    = acc_q;
    if (load_i) begin
      acc_d = prod_ext;
    end else if (accum_i) begin
      acc_d = acc_q + prod_ext;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;
endmodule

// File: rtl/qpsk_demodulator.sv
// Coherent QPSK demodulator: correlates one symbol window against cos/sin and decides the
// symbol from the dominant branch and its sign. QPSK_DEMOD_ERASURE_EN adds sym_erasure.
module qpsk_demodulator
  import qpsk_pkg::*;
#(
  parameter int SAMPLES_PER_SYM = 8,
  parameter int ACC_W           = 24 + $clog2(SAMPLES_PER_SYM)
`ifdef QPSK_DEMOD_ERASURE_EN
  , parameter int ERASE_THRESH  = 4096
`endif
) (
  input logic               clk,
  input logic               rst_n,
  qpsk_demodulator_if.slave bus
);
  localparam int              CNT_W    = $clog2(SAMPLES_PER_SYM + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLES_PER_SYM);

  qpsk_state_t             state_q;
  logic [CNT_W-1:0]        count_q;
  logic [CNT_W-1:0]        count_d;
  qpsk_sym_t               sym_out_q;
  logic                    sym_valid_q;
  logic [ACC_W-1:0]        corr_mag_q;
  logic                    sync_err_q;

  logic                    load;
  logic                    accum;
  logic signed [ACC_W-1:0] acc_c;
  logic signed [ACC_W-1:0] acc_s;
  logic signed [ACC_W-1:0] abs_c;
  logic signed [ACC_W-1:0] abs_s;
  logic signed [ACC_W-1:0] win_mag;
  qpsk_sym_t               win_sym;

  // Any qualified sym_start (re)loads; only ACCUM adds non-start samples.
  always_comb begin
    load    = bus.sample_valid && bus.sym_start;
    accum   = bus.sample_valid && !bus.sym_start && (state_q == ST_ACCUM);
    count_d = count_q + 1'b1;
  end

  qpsk_correlator #(.ACC_W(ACC_W)) u_corr_cos (
    .clk(clk), .rst_n(rst_n), .load_i(load), .accum_i(accum),
    .a_i(bus.rx_sample), .b_i(bus.cos_ref), .acc_o(acc_c)
  );

  qpsk_correlator #(.ACC_W(ACC_W)) u_corr_sin (
    .clk(clk), .rst_n(rst_n), .load_i(load), .accum_i(accum),
    .a_i(bus.rx_sample), .b_i(bus.sin_ref), .acc_o(acc_s)
  );

  // Decision uses the accumulators as held this cycle, before any reload lands; ties go to cos.
  always_comb begin
    abs_c = acc_c[ACC_W-1] ? -acc_c : acc_c;
    abs_s = acc_s[ACC_W-1] ? -acc_s : acc_s;
    if (abs_c >= abs_s) begin
      win_mag = abs_c;
      win_sym = acc_c[ACC_W-1] ? SYM_NEG_COS : SYM_POS_COS;
    end else begin
      win_mag = abs_s;
      win_sym = acc_s[ACC_W-1] ? SYM_NEG_SIN : SYM_POS_SIN;
    end
  end

`ifdef QPSK_DEMOD_ERASURE_EN
  logic sym_erasure_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sym_erasure_q <= 1'b0;
    end else if (state_q == ST_DECIDE) begin
      sym_erasure_q <= (win_mag < ACC_W'(ERASE_THRESH));
    end
  end
  assign bus.sym_erasure = sym_erasure_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      sym_out_q   <= SYM_NEG_COS;
      sym_valid_q <= 1'b0;
      corr_mag_q  <= '0;
      sync_err_q  <= 1'b0;
    end else begin
      sym_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (load) begin
            count_q <= CNT_W'(1);
            state_q <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (load) begin
            count_q    <= CNT_W'(1);
            sync_err_q <= 1'b1;
          end else if (bus.sample_valid) begin
            count_q <= count_d;
            if (count_d == CNT_LAST) begin
              state_q <= ST_DECIDE;
            end
          end
        end
        ST_DECIDE: begin
          sym_valid_q <= 1'b1;
          sym_out_q   <= win_sym;
          corr_mag_q  <= win_mag;
          if (load) begin
            count_q <= CNT_W'(1);
            state_q <= ST_ACCUM;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.sym_out   = sym_out_q;
  assign bus.sym_valid = sym_valid_q;
  assign bus.corr_mag  = corr_mag_q;
  assign bus.sync_err  = sync_err_q;
  assign bus.state     = state_q;
endmodule
